down_counter: RTL
=================

# down_counter

Loadable down-counter with a valid/ready load port, the counterpart of the team's up-counting `counter` block. It consumes the same `en`/`clkEn` qualifiers. It counts from a loaded value down to zero and signals terminal count with a one-cycle borrow pulse `bo`, optionally auto-reloading. It is used as a programmable interval timer beside the up-counter in the test designs of the NBGen flow.

## Interface
Parameters:
- `WIDTH`, 4: counter and load-value width in bits.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `en`  input  1  count enable.
- `clkEn`  input  1  clock-enable qualifier; tick = `en & clkEn`.
- `ld_valid`  input  1  load request.
- `ld_ready`  output  1  load can be accepted.
- `ld_value`  input  WIDTH  start value, sampled on handshake.
- `auto_reload`  input  1  reload mode, sampled on handshake.
- `stop`  input  1  synchronous abort of a running count.
- `count`  output  WIDTH  current value (registered).
- `bo`  output  1  borrow pulse at terminal count (registered).
- `busy`  output  1  high in RUN.
- `done`  output  1  high in DONE.

## Operation
- States are IDLE, RUN and DONE. Reset puts the block in IDLE with `count`=0, `bo`=0, `busy`=0, `done`=0, `ld_ready`=1, and the internal `reload_q`=0 and `mode_q`=0.
- `ld_ready` = 1 in IDLE and DONE, and 0 in RUN. `ld_valid` in RUN is ignored and never queued.
- Load accepted (`ld_valid & ld_ready`):
  - `count`←`ld_value`, `reload_q`←`ld_value`, `mode_q`←`auto_reload`.
  - If `ld_value`≠0, the next state is RUN.
  - If `ld_value`=0, the next state is DONE and `bo`←1.
- RUN, with the highest priority first:
  - `stop`=1: go to IDLE, `count` held, no `bo`, even if a tick is present.
  - No tick: hold.
  - Tick with `count`>1: `count`←`count`−1.
  - Tick with `count`=1 and `mode_q`=1: `count`←`reload_q`, `bo`←1, stay in RUN.
  - Tick with `count`=1 and `mode_q`=0: `count`←0, `bo`←1, go to DONE.
- DONE: `count` holds 0 and `done`=1 until a new load moves the block out. Ticks and `stop` are ignored.
- `bo` is 1 only for the single cycle after the terminal tick; otherwise it is 0.
- Arithmetic is unsigned at WIDTH bits. Because a count never decrements from 0, there is no underflow wrap.
- Auto-reload period is exactly `reload_q` ticks, and `count` never shows 0 in that mode.
- A reset assertion mid-operation forces the reset values immediately, regardless of the clock. Deassertion takes effect on the next rising edge.

## Timing
- Handshake at edge k: `count`=`ld_value` and `busy`=1 (or `done`=1 for a load of 0) from edge k. The first decrement can occur at edge k+1.
- `count` is visible one cycle after each tick edge. `bo` is asserted in the same cycle `count` shows 0 or the reload value.
- `done` rises in the same cycle as the final `bo`. `ld_ready` rises in that cycle too, so back-to-back reloading is possible with a one-cycle gap.
- Outputs are purely registered or state-decoded. There is no combinational path from inputs to outputs.

## Structure
- The shared package `counter_pkg` holds the state encoding constants `ST_IDLE`=2'b00, `ST_RUN`=2'b01 and `ST_DONE`=2'b10, plus the default `WIDTH`.
- The design is a single module with no sub-module. The tick qualifier and decrement are inline, as in `counter`.

## Test plan
- Load 5 (`auto_reload`=0, `en`=`clkEn`=1) → `count` 5,4,3,2,1,0; `bo`=1 only in the cycle `count`=0; `done`=1 and `count` holds 0 afterwards.
- Load 3 with `auto_reload`=1 over 9 ticks → `count` 3,2,1,3,2,1,3,2,1; `bo` pulses on every third tick; `busy` stays 1.
- Load 4, hold `en`=1 and toggle `clkEn` 1,0,1,0 → `count` 4,3,3,2,2; with `en`=0, `count` is frozen even while `clkEn`=1.
- At `count`=4 in RUN, assert `stop` together with a tick → IDLE, `count`=4, `bo`=0, `ld_ready`=1.
- Load 0 → DONE, `bo`=1 for one cycle; assert `ld_valid` with value 7 during RUN → `ld_ready`=0, `count` unaffected.
- Drive `rst`=0 asynchronously at `count`=6 in RUN → `count`=0, `busy`=0, `ld_ready`=1 before the next clock edge; after release, a load of 2 counts normally.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the up-counting `counter` and by
// `down_counter`.
//   CNT_WIDTH_DEFAULT : default counter/load width in bits.
//   ST_IDLE/ST_RUN/ST_DONE : state encodings.
//   state_e : typed FSM state built from those encodings.
package counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage : counter_pkg

// File: rtl/down_counter.sv
// down_counter: loadable down-counter / programmable interval timer.
// A value loaded over a valid/ready port counts down on every tick
// (en & clkEn) to zero. The terminal tick produces a one-cycle borrow pulse
// `bo`. With auto_reload set, the count restarts from the loaded value
// instead of stopping.
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   en, clkEn   : count qualifiers, tick = en & clkEn
//   ld_valid    : load request
//   ld_ready    : load can be accepted (IDLE or DONE)
//   ld_value    : start value, sampled on handshake
//   auto_reload : reload mode, sampled on handshake
//   stop        : synchronous abort of a running count
//   count       : current value (registered)
//   bo          : borrow pulse at terminal count (registered)
//   busy, done  : state decodes of RUN and DONE
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clkEn,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_value,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             bo_q, bo_d;
  logic             tick;

  assign tick = en & clkEn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      bo_q     <= bo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    bo_d     = 1'b0;
    case (state_q)
      // IDLE and DONE both accept loads. Ticks and stop do nothing here.
      S_IDLE, S_DONE: begin
        if (ld_valid) begin
          count_d  = ld_value;
          reload_d = ld_value;
          mode_d   = auto_reload;
          if (ld_value != '0) begin
            state_d = S_RUN;
          end else begin
            // A zero load is already at terminal count.
            state_d = S_DONE;
            bo_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Stop wins over a simultaneous tick and leaves count untouched.
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (mode_q) begin
            // Reload at 1 instead of passing through 0, so the period is
            // exactly reload_q ticks.
            count_d = reload_q;
            bo_d    = 1'b1;
          end else begin
            count_d = '0;
            bo_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign count    = count_q;
  assign bo       = bo_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign ld_ready = (state_q != S_RUN);

endmodule : down_counter
